// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DBITS_DEF        = 32;
  localparam int unsigned DMEMADDRBITS_DEF = 13;
  localparam int unsigned DMEMWORDBITS_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2
  } state_e;

  typedef logic port_id_t;

  localparam port_id_t PORT_A = 1'b0;
  localparam port_id_t PORT_B = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between port A and port B.
// DMEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise port A has fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic     a_req,
  input  logic     b_req,
  input  port_id_t last_id,
  output port_id_t win_id
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // On contention the port that was not granted last wins.
  always_comb begin
    win_id = PORT_B;
    if (a_req && b_req) begin
      win_id = (last_id == PORT_A) ? PORT_B : PORT_A;
    end else if (a_req) begin
      win_id = PORT_A;
    end
  end
`else
  logic unused_pick;
  assign unused_pick = last_id ^ b_req;

  always_comb begin
    win_id = a_req ? PORT_A : PORT_B;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory (1-cycle read).
// Arbitration mode set by DMEM_ARB_ROUND_ROBIN_EN (round-robin) or fixed A priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DBITS        = DBITS_DEF,
  parameter int unsigned DMEMADDRBITS = DMEMADDRBITS_DEF,
  parameter int unsigned DMEMWORDBITS = DMEMWORDBITS_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             a_req,
  input  logic                             a_we,
  input  logic [DBITS-1:0]                 a_addr,
  input  logic [DBITS-1:0]                 a_wdata,
  output logic                             a_gnt,
  output logic                             a_rvalid,
  output logic [DBITS-1:0]                 a_rdata,
  input  logic                             b_req,
  input  logic                             b_we,
  input  logic [DBITS-1:0]                 b_addr,
  input  logic [DBITS-1:0]                 b_wdata,
  output logic                             b_gnt,
  output logic                             b_rvalid,
  output logic [DBITS-1:0]                 b_rdata,
  output logic                             mem_we,
  output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_index,
  output logic [DBITS-1:0]                 mem_din,
  input  logic [DBITS-1:0]                 mem_dout
);

  localparam int unsigned IDXW = DMEMADDRBITS - DMEMWORDBITS;

  state_e               state_q, state_d;
  port_id_t             win_id;
  logic                 any_req;
  logic                 sel_we;
  logic [DBITS-1:0]     sel_addr;
  logic [DBITS-1:0]     sel_wdata;
  logic                 unused_addr_bits;

  port_id_t             id_q, id_d;
  port_id_t             last_id_q, last_id_d;
  logic                 we_q, we_d;
  logic                 a_gnt_q, a_gnt_d;
  logic                 b_gnt_q, b_gnt_d;
  logic                 a_rvalid_q, a_rvalid_d;
  logic                 b_rvalid_q, b_rvalid_d;
  logic                 mem_we_q, mem_we_d;
  logic [IDXW-1:0]      mem_index_q, mem_index_d;
  logic [DBITS-1:0]     mem_din_q, mem_din_d;
  logic [DBITS-1:0]     a_rdata_q, a_rdata_d;
  logic [DBITS-1:0]     b_rdata_q, b_rdata_d;

  assign any_req = a_req | b_req;

  dmem_arb_pick u_pick (
    .a_req   (a_req),
    .b_req   (b_req),
    .last_id (last_id_q),
    .win_id  (win_id)
  );

  assign sel_we    = (win_id == PORT_A) ? a_we    : b_we;
  assign sel_addr  = (win_id == PORT_A) ? a_addr  : b_addr;
  assign sel_wdata = (win_id == PORT_A) ? a_wdata : b_wdata;

  // Bits outside the word index are intentionally dropped (index wraps).
  assign unused_addr_bits = ^{sel_addr[DBITS-1:DMEMADDRBITS], sel_addr[DMEMWORDBITS-1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_req) state_d = ST_ACCESS;
      ST_ACCESS: state_d = we_q ? ST_IDLE : ST_RDATA;
      ST_RDATA:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Memory-side outputs are registered at arbitration so they are valid throughout ACCESS.
  always_comb begin
    id_d        = id_q;
    last_id_d   = last_id_q;
    we_d        = we_q;
    mem_index_d = mem_index_q;
    mem_din_d   = mem_din_q;
    mem_we_d    = 1'b0;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_rvalid_d  = 1'b0;
    b_rvalid_d  = 1'b0;
    a_rdata_d   = a_rvalid_q ? mem_dout : a_rdata_q;
    b_rdata_d   = b_rvalid_q ? mem_dout : b_rdata_q;

    if (state_q == ST_IDLE && any_req) begin
      id_d        = win_id;
      last_id_d   = win_id;
      we_d        = sel_we;
      mem_we_d    = sel_we;
      mem_index_d = sel_addr[DMEMADDRBITS-1:DMEMWORDBITS];
      mem_din_d   = sel_wdata;
      a_gnt_d     = (win_id == PORT_A);
      b_gnt_d     = (win_id == PORT_B);
    end

    if (state_q == ST_ACCESS && !we_q) begin
      a_rvalid_d = (id_q == PORT_A);
      b_rvalid_d = (id_q == PORT_B);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_q        <= PORT_A;
      last_id_q   <= PORT_B;
      we_q        <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_index_q <= '0;
      mem_din_q   <= '0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      id_q        <= id_d;
      last_id_q   <= last_id_d;
      we_q        <= we_d;
      mem_we_q    <= mem_we_d;
      mem_index_q <= mem_index_d;
      mem_din_q   <= mem_din_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign mem_we    = mem_we_q;
  assign mem_index = mem_index_q;
  assign mem_din   = mem_din_q;

  // Memory data arrives in RDATA, so it passes straight through and is held afterwards.
  assign a_rdata = a_rvalid_q ? mem_dout : a_rdata_q;
  assign b_rdata = b_rvalid_q ? mem_dout : b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 1-cycle-latency memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_we;
  logic [10:0] mem_index;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = 32'h0;
  logic [31:0] mem [0:2047];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_index] <= mem_din;
    mem_dout <= mem[mem_index];
  end

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .mem_we    (mem_we),
    .mem_index (mem_index),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  typedef struct {
    logic [1:0]  onehot;
    logic        we;
    logic [10:0] idx;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t gnt_q[$];
  exp_t rv_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic a_hold = 1'b0;
  logic b_hold = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue the grant (and, for reads with has_rv, the load) for an arbitration in cycle arb.
  task automatic push(input logic port, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input logic has_rv, input int arb);
    exp_t e;
    e.onehot = port ? 2'b01 : 2'b10;
    e.we     = we;
    e.idx    = addr[12:2];
    e.data   = wdata;
    e.cyc    = arb + 1;
    gnt_q.push_back(e);
    if (!we && has_rv) begin
      e.data = rdata;
      e.cyc  = arb + 2;
      rv_q.push_back(e);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (a_gnt || b_gnt) begin
      if (gnt_q.size() == 0) begin
        chk("gnt_unexpected", 64'({a_gnt, b_gnt}), 64'(0));
      end else begin
        e = gnt_q.pop_front();
        chk("gnt_port",  64'({a_gnt, b_gnt}), 64'(e.onehot));
        chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
        chk("mem_we",    64'(mem_we), 64'(e.we));
        chk("mem_index", 64'(mem_index), 64'(e.idx));
        if (e.we) chk("mem_din", 64'(mem_din), 64'(e.data));
      end
    end else if (mem_we) begin
      chk("mem_we_no_gnt", 64'(mem_we), 64'(0));
    end
    if (a_rvalid || b_rvalid) begin
      if (rv_q.size() == 0) begin
        chk("rvalid_unexpected", 64'({a_rvalid, b_rvalid}), 64'(0));
      end else begin
        e = rv_q.pop_front();
        chk("rv_port",  64'({a_rvalid, b_rvalid}), 64'(e.onehot));
        chk("rv_cycle", 64'(cyc), 64'(e.cyc));
        chk("rdata",    64'(a_rvalid ? a_rdata : b_rdata), 64'(e.data));
      end
    end
    if (a_gnt && !a_hold) a_req = 1'b0;
    if (b_gnt && !b_hold) b_req = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_a_gnt"},     64'(a_gnt), 64'(0));
    chk({tag, "_b_gnt"},     64'(b_gnt), 64'(0));
    chk({tag, "_a_rvalid"},  64'(a_rvalid), 64'(0));
    chk({tag, "_b_rvalid"},  64'(b_rvalid), 64'(0));
    chk({tag, "_mem_we"},    64'(mem_we), 64'(0));
    chk({tag, "_mem_index"}, 64'(mem_index), 64'(0));
    chk({tag, "_mem_din"},   64'(mem_din), 64'(0));
    chk({tag, "_a_rdata"},   64'(a_rdata), 64'(0));
    chk({tag, "_b_rdata"},   64'(b_rdata), 64'(0));
  endtask

  initial begin
    reset = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    ticks(2);
    check_idle_zero("reset");
    reset = 1'b1;
    tick();

    // A write 0x12345678 to 0x104
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h0000_0104; a_wdata = 32'h1234_5678;
    push(1'b0, 1'b1, a_addr, a_wdata, 32'h0, 1'b0, cyc);
    ticks(3);

    // Overwrite word 0x041 with 0xCAFEF00D, then read it back
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h0000_0104; a_wdata = 32'hCAFE_F00D;
    push(1'b0, 1'b1, a_addr, a_wdata, 32'h0, 1'b0, cyc);
    ticks(3);
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000_0104;
    push(1'b0, 1'b0, a_addr, 32'h0, 32'hCAFE_F00D, 1'b1, cyc);
    ticks(3);
    chk("a_rdata_hold", 64'(a_rdata), 64'(32'hCAFE_F00D));

    // B write with upper address bits set, then B read of the wrapped word
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'hF000_2008; b_wdata = 32'hA5A5_0001;
    push(1'b1, 1'b1, b_addr, b_wdata, 32'h0, 1'b0, cyc);
    ticks(3);
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h0000_0008;
    push(1'b1, 1'b0, b_addr, 32'h0, 32'hA5A5_0001, 1'b1, cyc);
    ticks(3);
    chk("b_rdata_hold", 64'(b_rdata), 64'(32'hA5A5_0001));

    // Both ports read continuously; each read occupies 3 cycles
    a_hold = 1'b1; b_hold = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000_0104;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h0000_0008;
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      if (k % 2 == 1) push(1'b1, 1'b0, b_addr, 32'h0, 32'hA5A5_0001, 1'b1, cyc + 3 * k);
      else            push(1'b0, 1'b0, a_addr, 32'h0, 32'hCAFE_F00D, 1'b1, cyc + 3 * k);
`else
      push(1'b0, 1'b0, a_addr, 32'h0, 32'hCAFE_F00D, 1'b1, cyc + 3 * k);
`endif
    end
    ticks(12);
    a_req = 1'b0; b_req = 1'b0;
    a_hold = 1'b0; b_hold = 1'b0;
    ticks(3);

    // A changes addr/we after arbitration; latched access must proceed
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000_0104;
    push(1'b0, 1'b0, a_addr, 32'h0, 32'hCAFE_F00D, 1'b1, cyc);
    tick();
    a_addr = 32'h0000_0008; a_we = 1'b1; a_wdata = 32'hDEAD_BEEF;
    ticks(2);
    a_we = 1'b0;
    ticks(2);

    // Reset while a read is in flight: no rvalid may follow
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000_0104;
    push(1'b0, 1'b0, a_addr, 32'h0, 32'h0, 1'b0, cyc);
    tick();
    reset = 1'b0;
    ticks(2);
    reset = 1'b1;
    ticks(3);
    check_idle_zero("post_abort");

    // Simultaneous writes after reset: A favoured first, B next
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h0000_0040; a_wdata = 32'h1111_0000;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h0000_0044; b_wdata = 32'h2222_0000;
    push(1'b0, 1'b1, a_addr, a_wdata, 32'h0, 1'b0, cyc);
    push(1'b1, 1'b1, b_addr, b_wdata, 32'h0, 1'b0, cyc + 2);
    ticks(5);

    // Read back B's word to confirm the data reached memory
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000_0044;
    push(1'b0, 1'b0, a_addr, 32'h0, 32'h2222_0000, 1'b1, cyc);
    ticks(4);

    chk("gnt_pending",    64'(gnt_q.size()), 64'(0));
    chk("rvalid_pending", 64'(rv_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
